// File: rtl/floppy_image_server_if.sv
// floppy_image_server_if: sector handshake towards the track buffer plus the image store port.
// slave is the server side; master is the environment (track buffer and image store).
interface floppy_image_server_if;
  logic [10:0] sd_lba;
  logic [1:0] sd_rd;
  logic [1:0] sd_wr;
  logic sd_busy;
  logic sd_done;
  logic [8:0] sd_addr;
  logic sd_data_en;
  logic [7:0] sd_data_in;
  logic [7:0] sd_data_out;
  logic img_req;
  logic img_we;
  logic [20:0] img_addr;
  logic [7:0] img_wdata;
  logic [7:0] img_rdata;
  logic img_ack;
  modport slave (
    input sd_lba, sd_rd, sd_wr, sd_data_out, img_rdata, img_ack,
    output sd_busy, sd_done, sd_addr, sd_data_en, sd_data_in, img_req, img_we, img_addr, img_wdata
  );
  modport master (
    output sd_lba, sd_rd, sd_wr, sd_data_out, img_rdata, img_ack,
    input sd_busy, sd_done, sd_addr, sd_data_en, sd_data_in, img_req, img_we, img_addr, img_wdata
  );
endinterface

// File: rtl/floppy_image_server.sv
// floppy_image_server: serves 512-byte floppy sector reads/writes byte by byte from a RAM image store.
module floppy_image_server #(
  parameter int MAX_SECTORS = 1600
) (
  input logic clk,
  input logic rst,
  floppy_image_server_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, RD_REQ, RD_PUSH, WR_ADDR, WR_CAP, WR_REQ, FINISH} state_t;
  localparam logic [11:0] MAX = 12'(MAX_SECTORS);
  state_t state, nxt;
  logic drv, wr, oor, hit, last;
  logic [10:0] lba;
  logic [8:0] cnt;
  logic [7:0] rbyte, wbyte;
  assign hit = |{bus.sd_rd, bus.sd_wr};
  assign last = cnt == 9'd511;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = hit ? START : IDLE;
      START:   nxt = wr ? WR_ADDR : RD_REQ;
      RD_REQ:  nxt = (oor || bus.img_ack) ? RD_PUSH : RD_REQ;
      RD_PUSH: nxt = last ? FINISH : RD_REQ;
      WR_ADDR: nxt = WR_CAP;
      WR_CAP:  nxt = !oor ? WR_REQ : last ? FINISH : WR_ADDR;
      WR_REQ:  nxt = !bus.img_ack ? WR_REQ : last ? FINISH : WR_ADDR;
      default: nxt = IDLE;
    endcase
  end
  // drive select encodes rd[0] > rd[1] > wr[0] > wr[1]
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      drv <= 1'b0;
      wr <= 1'b0;
      oor <= 1'b0;
      lba <= '0;
      cnt <= '0;
      rbyte <= '0;
      wbyte <= '0;
    end else
      case (state)
        IDLE:
          if (hit) begin
            drv <= !bus.sd_rd[0] && (bus.sd_rd[1] || !bus.sd_wr[0]);
            wr <= !(|bus.sd_rd);
            lba <= bus.sd_lba;
            oor <= {1'b0, bus.sd_lba} >= MAX;
            cnt <= '0;
          end
        RD_REQ:
          if (oor) rbyte <= '0;
          else if (bus.img_ack) rbyte <= bus.img_rdata;
        RD_PUSH: if (!last) cnt <= cnt + 9'd1;
        WR_CAP: begin
          wbyte <= bus.sd_data_out;
          if (oor && !last) cnt <= cnt + 9'd1;
        end
        WR_REQ: if (bus.img_ack && !last) cnt <= cnt + 9'd1;
        default: ;
      endcase
  always_comb begin
    bus.sd_busy = state != IDLE && state != FINISH;
    bus.sd_done = state == FINISH;
    bus.sd_data_en = state == RD_PUSH;
    bus.sd_addr = bus.sd_busy ? cnt : '0;
    bus.sd_data_in = state == RD_PUSH ? rbyte : '0;
    bus.img_req = (state == RD_REQ && !oor) || state == WR_REQ;
    bus.img_we = state == WR_REQ;
    bus.img_addr = bus.img_req ? {drv, lba, cnt} : '0;
    bus.img_wdata = bus.img_we ? wbyte : '0;
  end
endmodule

// File: tb/tb_floppy_image_server.sv
// tb_floppy_image_server: directed tests with an image store model, a registered
// initiator buffer model and an output monitor.
module tb_floppy_image_server;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  floppy_image_server_if bus();
  floppy_image_server #(.MAX_SECTORS(1600)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_checks = 0;
  int n_fails = 0;
  logic [7:0] mem [0:2097151];
  int lat_max = 1;
  int wait_c = 0;
  int wr_count = 0;
  bit pending = 0;
  int req_cycles = 0;
  int done_cnt = 0;
  int busy_cycles = 0;
  int viol = 0;
  bit prev_en = 0;
  bit prev_busy = 0;
  bit seen = 0;
  bit first_drv = 0;
  bit first_we = 0;
  int rd_addr_q[$];
  int rd_data_q[$];
  // image store: ack after 1..lat_max cycles, ack held one cycle
  always @(negedge clk) begin
    if (!rst) begin
      pending = 0;
      bus.img_ack = 1'b0;
      bus.img_rdata = 8'h00;
    end else if (bus.img_ack) bus.img_ack = 1'b0;
    else if (bus.img_req) begin
      if (!pending) begin
        pending = 1;
        wait_c = int'($urandom_range(lat_max, 1));
      end else begin
        wait_c = wait_c - 1;
        if (wait_c == 0) begin
          pending = 0;
          bus.img_ack = 1'b1;
          if (bus.img_we) begin
            mem[bus.img_addr] = bus.img_wdata;
            wr_count++;
          end else bus.img_rdata = mem[bus.img_addr];
        end
      end
    end
  end
  // initiator buffer holds ~index; its output is registered
  always @(posedge clk) bus.sd_data_out <= ~bus.sd_addr[7:0];
  always @(negedge clk) begin
    if (bus.img_req) req_cycles++;
    if (bus.sd_done) done_cnt++;
    if (bus.sd_busy) busy_cycles++;
    if (bus.sd_busy && !prev_busy) seen = 0;
    if (bus.img_req && !seen) begin
      seen = 1;
      first_drv = bus.img_addr[20];
      first_we = bus.img_we;
    end
    if (bus.sd_data_en) begin
      rd_addr_q.push_back(int'(bus.sd_addr));
      rd_data_q.push_back(int'(bus.sd_data_in));
      if (prev_en || bus.sd_done) viol++;
    end
    if (bus.sd_done && bus.sd_busy) viol++;
    prev_en = bus.sd_data_en;
    prev_busy = bus.sd_busy;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic xfer(input logic [1:0] rd, input logic [1:0] wr, input logic [10:0] lba,
                      input logic [1:0] rd_keep, input logic [1:0] wr_keep,
                      output bit got_busy, output bit got_done);
    int d0;
    d0 = done_cnt;
    got_busy = 0;
    got_done = 0;
    bus.sd_lba = lba;
    bus.sd_rd = rd;
    bus.sd_wr = wr;
    for (int i = 0; i < 10 && !got_busy; i++) begin
      tick(1);
      got_busy = bus.sd_busy;
    end
    bus.sd_rd = rd_keep;
    bus.sd_wr = wr_keep;
    for (int i = 0; i < 20000 && !got_done; i++) begin
      tick(1);
      got_done = done_cnt != d0;
    end
  endtask
  task automatic test_reset;
    int r0;
    rst = 1'b0;
    tick(3);
    n_checks++;
    if ({bus.sd_busy, bus.sd_done, bus.sd_data_en, bus.img_req, bus.img_we} !== 5'b0) begin
      n_fails++;
      $display("FAIL reset_ctrl: got %b expected 00000", {bus.sd_busy, bus.sd_done, bus.sd_data_en, bus.img_req, bus.img_we});
    end
    n_checks++;
    if ({bus.sd_addr, bus.sd_data_in, bus.img_addr, bus.img_wdata} !== 46'd0) begin
      n_fails++;
      $display("FAIL reset_data: got %h expected 0", {bus.sd_addr, bus.sd_data_in, bus.img_addr, bus.img_wdata});
    end
    rst = 1'b1;
    r0 = req_cycles;
    tick(100);
    n_checks++;
    if (req_cycles - r0 !== 0) begin
      n_fails++;
      $display("FAIL idle_no_req: got %0d req cycles expected 0", req_cycles - r0);
    end
    n_checks++;
    if ({bus.sd_busy, bus.sd_done, bus.sd_data_en, bus.img_req} !== 4'b0) begin
      n_fails++;
      $display("FAIL idle_outputs: got %b expected 0000", {bus.sd_busy, bus.sd_done, bus.sd_data_en, bus.img_req});
    end
  endtask
  task automatic test_read_drive0;
    int q0, b0, d0, n, bad;
    bit gb, gd;
    lat_max = 1;
    q0 = rd_addr_q.size();
    b0 = busy_cycles;
    d0 = done_cnt;
    xfer(2'b01, 2'b00, 11'd5, 2'b00, 2'b00, gb, gd);
    n_checks++;
    if ({gb, gd} !== 2'b11) begin
      n_fails++;
      $display("FAIL read_handshake: got busy/done %b expected 11", {gb, gd});
    end
    n = rd_addr_q.size() - q0;
    n_checks++;
    if (n !== 512) begin
      n_fails++;
      $display("FAIL read_count: got %0d strobes expected 512", n);
    end
    bad = 0;
    for (int i = 0; i < n && i < 512; i++)
      if (rd_addr_q[q0+i] != i || rd_data_q[q0+i] != (((5 * 512 + i) & 255) ^ 'h5A)) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fails++;
      $display("FAIL read_data: got %0d bad bytes expected 0", bad);
    end
    n_checks++;
    if ({first_drv, first_we} !== 2'b00) begin
      n_fails++;
      $display("FAIL read_drive: got drv/we %b expected 00", {first_drv, first_we});
    end
    n_checks++;
    if (busy_cycles - b0 !== 1537) begin
      n_fails++;
      $display("FAIL read_timing: got %0d busy cycles expected 1537", busy_cycles - b0);
    end
    tick(3);
    n_checks++;
    if (done_cnt - d0 !== 1 || bus.sd_busy !== 1'b0) begin
      n_fails++;
      $display("FAIL read_done: got %0d done pulses busy %b expected 1 busy 0", done_cnt - d0, bus.sd_busy);
    end
    n_checks++;
    if (viol !== 0) begin
      n_fails++;
      $display("FAIL strobe_rules: got %0d violations expected 0", viol);
    end
  endtask
  task automatic test_write_drive1;
    int w0, bad;
    bit gb, gd;
    logic [20:0] a;
    lat_max = 5;
    w0 = wr_count;
    xfer(2'b00, 2'b10, 11'd1599, 2'b00, 2'b00, gb, gd);
    n_checks++;
    if ({gb, gd} !== 2'b11) begin
      n_fails++;
      $display("FAIL write_handshake: got busy/done %b expected 11", {gb, gd});
    end
    n_checks++;
    if (wr_count - w0 !== 512) begin
      n_fails++;
      $display("FAIL write_count: got %0d writes expected 512", wr_count - w0);
    end
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      a = {1'b1, 11'd1599, 9'(i)};
      if (mem[a] !== ~8'(i)) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fails++;
      $display("FAIL write_data: got %0d bad bytes expected 0", bad);
    end
    n_checks++;
    if ({first_drv, first_we} !== 2'b11) begin
      n_fails++;
      $display("FAIL write_drive: got drv/we %b expected 11", {first_drv, first_we});
    end
  endtask
  task automatic test_oor_read;
    int q0, b0, r0, n, bad;
    bit gb, gd;
    lat_max = 1;
    q0 = rd_addr_q.size();
    b0 = busy_cycles;
    r0 = req_cycles;
    xfer(2'b01, 2'b00, 11'd1600, 2'b00, 2'b00, gb, gd);
    n_checks++;
    if ({gb, gd} !== 2'b11) begin
      n_fails++;
      $display("FAIL oor_handshake: got busy/done %b expected 11", {gb, gd});
    end
    n_checks++;
    if (req_cycles - r0 !== 0) begin
      n_fails++;
      $display("FAIL oor_no_req: got %0d req cycles expected 0", req_cycles - r0);
    end
    n = rd_addr_q.size() - q0;
    bad = 0;
    for (int i = 0; i < n && i < 512; i++)
      if (rd_addr_q[q0+i] != i || rd_data_q[q0+i] != 0) bad++;
    n_checks++;
    if (n !== 512 || bad !== 0) begin
      n_fails++;
      $display("FAIL oor_data: got %0d strobes %0d bad expected 512 strobes 0 bad", n, bad);
    end
    n_checks++;
    if (busy_cycles - b0 !== 1025) begin
      n_fails++;
      $display("FAIL oor_timing: got %0d busy cycles expected 1025", busy_cycles - b0);
    end
  endtask
  task automatic test_simultaneous;
    int bad;
    bit gb, gd;
    logic [20:0] a;
    lat_max = 1;
    xfer(2'b11, 2'b01, 11'd7, 2'b10, 2'b01, gb, gd);
    n_checks++;
    if ({gd, first_drv, first_we} !== 3'b100) begin
      n_fails++;
      $display("FAIL prio_first: got done/drv/we %b expected 100", {gd, first_drv, first_we});
    end
    xfer(2'b10, 2'b01, 11'd7, 2'b00, 2'b01, gb, gd);
    n_checks++;
    if ({gd, first_drv, first_we} !== 3'b110) begin
      n_fails++;
      $display("FAIL prio_second: got done/drv/we %b expected 110", {gd, first_drv, first_we});
    end
    xfer(2'b00, 2'b01, 11'd3, 2'b00, 2'b00, gb, gd);
    n_checks++;
    if ({gd, first_drv, first_we} !== 3'b101) begin
      n_fails++;
      $display("FAIL prio_third: got done/drv/we %b expected 101", {gd, first_drv, first_we});
    end
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      a = {1'b0, 11'd3, 9'(i)};
      if (mem[a] !== ~8'(i)) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fails++;
      $display("FAIL prio_write_data: got %0d bad bytes expected 0", bad);
    end
  endtask
  task automatic test_reset_mid_write;
    int w0, d0, q0, n, bad;
    bit gb, gd, hit;
    logic [20:0] a;
    lat_max = 1;
    w0 = wr_count;
    d0 = done_cnt;
    bus.sd_lba = 11'd10;
    bus.sd_wr = 2'b01;
    gb = 0;
    for (int i = 0; i < 10 && !gb; i++) begin
      tick(1);
      gb = bus.sd_busy;
    end
    bus.sd_wr = 2'b00;
    hit = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      tick(1);
      hit = wr_count - w0 == 200;
    end
    n_checks++;
    if ({gb, hit} !== 2'b11) begin
      n_fails++;
      $display("FAIL midrst_progress: got busy/reached %b expected 11", {gb, hit});
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.sd_busy !== 1'b0 || bus.img_req !== 1'b0) begin
      n_fails++;
      $display("FAIL midrst_busy: got busy %b req %b expected 0 0", bus.sd_busy, bus.img_req);
    end
    tick(5);
    rst = 1'b1;
    tick(5);
    n_checks++;
    if (wr_count - w0 !== 200 || done_cnt - d0 !== 0) begin
      n_fails++;
      $display("FAIL midrst_writes: got %0d writes %0d done expected 200 writes 0 done", wr_count - w0, done_cnt - d0);
    end
    a = {1'b0, 11'd10, 9'd199};
    n_checks++;
    if (mem[a] !== 8'h38) begin
      n_fails++;
      $display("FAIL midrst_last_byte: got %h expected 38", mem[a]);
    end
    a = {1'b0, 11'd10, 9'd200};
    n_checks++;
    if (mem[a] !== 8'h92) begin
      n_fails++;
      $display("FAIL midrst_untouched: got %h expected 92", mem[a]);
    end
    q0 = rd_addr_q.size();
    xfer(2'b01, 2'b00, 11'd5, 2'b00, 2'b00, gb, gd);
    n = rd_addr_q.size() - q0;
    bad = 0;
    for (int i = 0; i < n && i < 512; i++)
      if (rd_addr_q[q0+i] != i || rd_data_q[q0+i] != (i & 255 ^ 'h5A)) bad++;
    n_checks++;
    if ({gb, gd} !== 2'b11 || n !== 512 || bad !== 0) begin
      n_fails++;
      $display("FAIL midrst_reread: got busy/done %b %0d strobes %0d bad expected 11 512 0", {gb, gd}, n, bad);
    end
  endtask
  initial begin
    for (int a = 0; a < 2097152; a++) mem[a] = 8'(a) ^ 8'h5A;
    bus.sd_lba = '0;
    bus.sd_rd = '0;
    bus.sd_wr = '0;
    test_reset();
    test_read_drive0();
    test_write_drive1();
    test_oor_read();
    test_simultaneous();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/floppy_image_server.md
# floppy_image_server

Responder side of the floppy sector interface. It accepts 512-byte sector read/write requests from the floppy track buffer (`sd_lba`/`sd_rd`/`sd_wr`) and services them byte by byte from a RAM-resident floppy image store. It generates the `sd_busy`/`sd_done`/`sd_addr`/`sd_data_en` handshake that the track buffer consumes. It sits between the track buffer and the SDRAM image arbiter and replaces the physical SD path when images are preloaded to RAM.

## Interface

Parameters:
- `MAX_SECTORS`, default 1600: sectors per drive image. An LBA at or above this value is out of range.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-low (0 = reset).
- `sd_lba` in 11: sector number within the image. Sampled when a request is accepted.
- `sd_rd` in 2: per-drive read request level; bit0 = internal, bit1 = external.
- `sd_wr` in 2: per-drive write request level.
- `sd_busy` out 1: high from the cycle after acceptance until the transfer ends.
- `sd_done` out 1: one-cycle pulse in the cycle `sd_busy` falls.
- `sd_addr` out 9: byte index within the sector.
- `sd_data_en` out 1: one-cycle read-data strobe.
- `sd_data_in` out 8: read data to the initiator; valid while `sd_data_en` is high.
- `sd_data_out` in 8: write data from the initiator. It is a registered copy of the initiator buffer at `sd_addr`.
- `img_req` out 1: image store access request; held until `img_ack`.
- `img_we` out 1: 1 = write, 0 = read; stable while `img_req` is high.
- `img_addr` out 21: {drive, lba[10:0], byte[8:0]}.
- `img_wdata` out 8: write byte.
- `img_rdata` in 8: read byte; valid in the cycle `img_ack` is high.
- `img_ack` in 1: one-cycle completion; earliest one cycle after `img_req` rises.

## Operation

States: IDLE, START, RD_REQ, RD_PUSH, WR_ADDR, WR_CAP, WR_REQ, FINISH.

- **IDLE:** samples the request levels.
  - Priority: `sd_rd[0]` > `sd_rd[1]` > `sd_wr[0]` > `sd_wr[1]`.
  - On a hit: latch drive, direction and `sd_lba`; set `oor = (sd_lba >= MAX_SECTORS)`; clear the byte counter `cnt` (9 bits); go to START.
  - Requests not selected are ignored. They are still asserted after FINISH and are served in a later IDLE.
- **START:** `sd_busy` := 1. Next state is RD_REQ for a read, WR_ADDR for a write.
- **RD_REQ:**
  - If `oor`: skip the memory access, use byte 0x00, go to RD_PUSH.
  - Otherwise: raise `img_req` with `img_we` = 0 and `img_addr` = {drive, lba, cnt`}`. On `img_ack`, latch `img_rdata`, drop `img_req` and go to RD_PUSH.
- **RD_PUSH:** drives `sd_data_en` = 1 for exactly one cycle, with `sd_addr` = `cnt` and `sd_data_in` = the latched byte.
  - If `cnt` = 511, go to FINISH.
  - Otherwise increment `cnt` and go to RD_REQ.
- **WR_ADDR:** `sd_addr` := `cnt`; wait one cycle so the initiator can register its buffer output.
- **WR_CAP:** capture `sd_data_out` into `img_wdata`.
  - If `oor`: skip WR_REQ. Discard the byte and advance as below.
  - Otherwise go to WR_REQ.
- **WR_REQ:** hold `img_req` with `img_we` = 1 until `img_ack`. Then:
  - If `cnt` = 511, go to FINISH.
  - Otherwise increment `cnt` and go to WR_ADDR.
- **FINISH:** `sd_busy` := 0 and `sd_done` := 1 for one cycle; return to IDLE.
- **Arithmetic:** `cnt` does not wrap mid-transfer; the 511 check ends the transfer first. `img_addr` is a plain concatenation with no offset arithmetic.
- **Reset:** asserting reset (low) at any time, including mid-transfer, forces IDLE and clears every output.
  - Bytes already written stay in the image store.
  - The initiator sees `sd_busy` drop without `sd_done`.

## Timing

- **Reset values:** `sd_busy`, `sd_done`, `sd_data_en`, `img_req`, `img_we` = 0; `sd_addr`, `sd_data_in`, `img_addr`, `img_wdata` = 0.
- **Request to `sd_busy`:** 2 cycles (IDLE sample, START register). The initiator drops its request after seeing `sd_busy`.
- **Read:**
  - Per byte: (ack latency + 1) cycles for RD_REQ plus 1 cycle for RD_PUSH.
  - `sd_data_en` never rises in consecutive cycles.
  - With a 1-cycle ack, a sector takes 1536 cycles plus START/FINISH.
- **Out-of-range read:** 2 cycles per byte; `img_req` never asserts.
- **Write:**
  - `sd_data_out` is sampled on the 2nd rising edge after `sd_addr` changes.
  - Per byte: 2 cycles plus WR_REQ.
- **`sd_done`:** coincides with the `sd_busy` falling cycle and never overlaps `sd_data_en`.
- **`img_*` stability:** all `img_*` outputs are stable from `img_req` rise through the `img_ack` cycle.

## Test plan

- **Reset:** hold `rst` = 0, then release. All outputs read 0, the FSM is in IDLE, and `img_req` stays 0 for 100 idle cycles.
- **Read, drive 0:** store byte = addr[7:0] ^ 0x5A; `sd_rd` = 01, `sd_lba` = 5. Expect:
  - 512 `sd_data_en` pulses with `sd_addr` 0..511 in order.
  - Data (5·512 + i)[7:0] ^ 0x5A.
  - `img_addr[20]` = 0.
  - A single `sd_done` pulse, after which `sd_busy` = 0.
- **Write, drive 1:** `sd_wr` = 10, `sd_lba` = 1599; the initiator model returns `~sd_addr[7:0]` one cycle late. Expect 512 store writes at {1, 1599, i} with data `~i[7:0]`, and random 1–5 cycle ack latency tolerated.
- **Out-of-range read:** `sd_rd` = 01, `sd_lba` = 1600. Expect 512 bytes of 0x00, no `img_req`, and a normal `sd_busy`/`sd_done` sequence.
- **Simultaneous requests:** `sd_rd` = 11 and `sd_wr` = 01 asserted together.
  - Drive 0 read is served first.
  - With requests kept high, the next transactions are drive 1 read, then drive 0 write.
- **Reset mid-write:** pull `rst` low at `cnt` = 200. Expect:
  - `sd_busy` = 0 immediately and no `sd_done`.
  - Exactly 200 store writes are completed.
  - A new read after release completes normally.
